sys_cmd_responder: RTL and testbench
====================================

# sys_cmd_responder

Command-frame responder on the parallel side of the UART pair. Consumes validated bytes from the UART receiver, decodes register-write, register-read and ALU command frames, and drives the register file and ALU. Returns read data and ALU results to the UART transmitter through a valid/busy handshake. Single clock domain; RX bytes arrive already synchronised to `clk`.

## Interface

**Parameters**
- `DATA_WIDTH`, 8: byte width of RX/TX and register data.
- `ADDR_WIDTH`, 4: register-file address width.
- `ALU_FUN_WIDTH`, 4: ALU function code width.

**Ports**
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `RST`, in, 1: asynchronous, active-low reset.
- `RX_P_DATA`, in, DATA_WIDTH: received byte.
- `RX_D_VLD`, in, 1: one-cycle pulse; `RX_P_DATA` is valid.
- `WrEn`, out, 1: register-file write strobe, one cycle.
- `RdEn`, out, 1: register-file read strobe, one cycle.
- `Address`, out, ADDR_WIDTH: register-file address.
- `WrData`, out, DATA_WIDTH: register-file write data.
- `RdData`, in, DATA_WIDTH: register-file read data.
- `RdData_Valid`, in, 1: `RdData` is valid.
- `ALU_EN`, out, 1: ALU start strobe, one cycle.
- `ALU_FUN`, out, ALU_FUN_WIDTH: ALU function code.
- `ALU_OUT`, in, 2*DATA_WIDTH: ALU result.
- `OUT_Valid`, in, 1: `ALU_OUT` is valid.
- `TX_P_DATA`, out, DATA_WIDTH: byte to transmit.
- `TX_D_VLD`, out, 1: transmit request.
- `TX_busy`, in, 1: transmitter is serialising a frame.

## Operation

- **Frame formats** (first byte is the opcode):
  - `0xAA`, write: ADDR, DATA. No reply.
  - `0xBB`, read: ADDR. Reply is 1 byte, `RdData`.
  - `0xCC`, ALU with operands: A, B, FUN. A is written to register 0x0 and B to register 0x1, then the ALU runs. Reply is 2 bytes, LSB first.
  - `0xDD`, ALU without operands: FUN. Reply is 2 bytes, LSB first.
- Any other opcode in IDLE is discarded; the FSM stays in IDLE.
- **FSM states:** IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN, ALU_WAIT, TX_REQ, TX_HOLD.
- **Transitions** (on `RX_D_VLD` unless noted):
  - IDLE → WR_ADDR / RD_ADDR / OP_A / ALU_FUN, per opcode.
  - WR_ADDR → WR_DATA (latch ADDR).
  - WR_DATA → IDLE (issue write).
  - RD_ADDR → RD_WAIT (issue `RdEn`).
  - RD_WAIT → TX_REQ on `RdData_Valid`.
  - OP_A → OP_B (write A to 0x0).
  - OP_B → ALU_FUN (write B to 0x1).
  - ALU_FUN → ALU_WAIT (issue `ALU_EN` with FUN).
  - ALU_WAIT → TX_REQ on `OUT_Valid`.
- **Reply buffer:** 2 bytes plus a byte counter (1 or 2). It is loaded on the RD_WAIT or ALU_WAIT exit.
- **TX handshake:**
  - In TX_REQ, wait until `TX_busy` is low. Then assert `TX_D_VLD` with `TX_P_DATA` stable.
  - Hold both until `TX_busy` is sampled high. Then deassert and go to TX_HOLD.
  - In TX_HOLD, wait for `TX_busy` low. If bytes remain, go to TX_REQ with the next byte; otherwise go to IDLE.
- `RX_D_VLD` is ignored in RD_WAIT, ALU_WAIT, TX_REQ and TX_HOLD. Those bytes are dropped.
- No timeouts. A missing `RdData_Valid` or `OUT_Valid` stalls the FSM until reset.

## Timing

- **Reset values:** all outputs are 0 and the FSM is in IDLE. Reset mid-frame or mid-reply aborts immediately; no partial reply is sent after reset.
- **Write strobe:** `WrEn`, `Address` and `WrData` are registered. `WrEn` is high for exactly the cycle after the `RX_D_VLD` that completes the write.
- **Read strobe:** `RdEn` is high for exactly 1 cycle, the cycle after the ADDR byte. `Address` holds until RD_WAIT exits.
- **ALU strobe:** `ALU_EN` is high for 1 cycle after the FUN byte. `ALU_FUN` holds until `OUT_Valid`.
- **Write-to-ALU order:** for `0xCC`, the B write occurs at least 1 cycle before `ALU_EN`.
- **Reply latency:**
  - `TX_D_VLD` rises 1 cycle after `RdData_Valid` / `OUT_Valid` is sampled, provided `TX_busy` is low.
  - Between reply bytes there is ≥1 cycle with `TX_D_VLD` low.
  - `RdData_Valid` / `OUT_Valid` coincident with a new `RX_D_VLD` gives the valid priority; the byte is dropped.
- **Widths:** `ALU_OUT[7:0]` is sent first, then `ALU_OUT[15:8]`. For 8-bit opcodes and FUN, the upper bits beyond `ALU_FUN_WIDTH` are truncated.

## Structure

- **Shared package `sys_ctrl_pkg`:**
  - Opcode constants: `CMD_WR=8'hAA`, `CMD_RD=8'hBB`, `CMD_ALU_OP=8'hCC`, `CMD_ALU_NOP=8'hDD`.
  - Operand addresses: `OPA_ADDR=0`, `OPB_ADDR=1`.
  - FSM state enum.
- **One sub-module, `tx_byte_seq`:** reply buffer, byte counter and the TX_REQ/TX_HOLD handshake. Its interface is load, byte count, 16-bit data and done.

## Test plan

- **Write:** RX AA, 05, 3C → `WrEn` for 1 cycle with `Address`=5 and `WrData`=0x3C. No `TX_D_VLD`.
- **Read:** RX BB, 05; register file returns 0x3C with `RdData_Valid` 2 cycles after `RdEn` → one TX byte 0x3C. `TX_D_VLD` is held until `TX_busy` rises.
- **ALU with operands:** RX CC, 0A, 03, 02; `ALU_OUT`=0x001E → writes 0x0A→addr 0 and 0x03→addr 1, then `ALU_EN` with FUN=2. TX bytes 0x1E, then 0x00, the second only after `TX_busy` falls.
- **ALU without operands:** RX DD, 01; `ALU_OUT`=0xABCD → TX 0xCD then 0xAB.
- **Drops:** RX 0x55 in IDLE → ignored. RX bytes during a reply → dropped. A following AA, 02, 7F is still executed correctly.
- **Reset mid-reply:** assert `RST` during TX_HOLD between the ALU reply bytes → outputs go to 0 asynchronously and the second byte is never sent.

Source files
------------

// File: rtl/sys_cmd_responder_pkg.sv
// Shared constants for the UART command responder: opcodes, operand
// register addresses and FSM state encodings.
package sys_ctrl_pkg;

   localparam logic [7:0] CMD_WR      = 8'hAA;
   localparam logic [7:0] CMD_RD      = 8'hBB;
   localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
   localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

   localparam int OPA_ADDR = 0;
   localparam int OPB_ADDR = 1;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE     = 4'd0;
   localparam state_t ST_WR_ADDR  = 4'd1;
   localparam state_t ST_WR_DATA  = 4'd2;
   localparam state_t ST_RD_ADDR  = 4'd3;
   localparam state_t ST_RD_WAIT  = 4'd4;
   localparam state_t ST_OP_A     = 4'd5;
   localparam state_t ST_OP_B     = 4'd6;
   localparam state_t ST_ALU_FUN  = 4'd7;
   localparam state_t ST_ALU_WAIT = 4'd8;
   localparam state_t ST_TX_REQ   = 4'd9;
   localparam state_t ST_TX_HOLD  = 4'd10;

endpackage

// File: rtl/sys_cmd_responder_if.sv
// Bus between the command responder and its UART RX/TX, register file and ALU.
// master = responder side, slave = peripheral side.
interface sys_cmd_responder_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_FUN_WIDTH = 4
);
   logic [DATA_WIDTH-1:0]    RX_P_DATA;
   logic                     RX_D_VLD;
   logic                     WrEn;
   logic                     RdEn;
   logic [ADDR_WIDTH-1:0]    Address;
   logic [DATA_WIDTH-1:0]    WrData;
   logic [DATA_WIDTH-1:0]    RdData;
   logic                     RdData_Valid;
   logic                     ALU_EN;
   logic [ALU_FUN_WIDTH-1:0] ALU_FUN;
   logic [2*DATA_WIDTH-1:0]  ALU_OUT;
   logic                     OUT_Valid;
   logic [DATA_WIDTH-1:0]    TX_P_DATA;
   logic                     TX_D_VLD;
   logic                     TX_busy;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
      output WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, TX_P_DATA, TX_D_VLD
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, ALU_OUT, OUT_Valid, TX_busy,
      input  WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, TX_P_DATA, TX_D_VLD
   );
endinterface

// File: rtl/sys_cmd_responder_tx_byte_seq.sv
// Reply sequencer: buffers up to two bytes and feeds them LSB first to the
// UART transmitter through the valid/busy handshake.
module tx_byte_seq
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic                    load_i,
   input  logic [1:0]              nbytes_i,
   input  logic [2*DATA_WIDTH-1:0] data_i,
   input  logic                    tx_busy_i,
   output logic                    tx_vld_o,
   output logic [DATA_WIDTH-1:0]   tx_data_o,
   output logic                    done_o
);

   state_t                  phase_q, phase_d;
   logic [2*DATA_WIDTH-1:0] buf_q, buf_d;
   logic [1:0]              cnt_q, cnt_d;
   logic                    vld_q, vld_d;

   always_comb begin
      phase_d = phase_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      vld_d   = vld_q;
      done_o  = 1'b0;
      case (phase_q)
         ST_TX_REQ: begin
            if (!vld_q) begin
               if (!tx_busy_i) vld_d = 1'b1;
            end else if (tx_busy_i) begin
               vld_d   = 1'b0;
               phase_d = ST_TX_HOLD;
            end
         end
         ST_TX_HOLD: begin
            // Returning to REQ with vld low guarantees a gap between bytes.
            if (!tx_busy_i) begin
               if (cnt_q <= 2'd1) begin
                  done_o  = 1'b1;
                  phase_d = ST_IDLE;
               end else begin
                  cnt_d   = cnt_q - 2'd1;
                  buf_d   = buf_q >> DATA_WIDTH;
                  phase_d = ST_TX_REQ;
               end
            end
         end
         default: begin
            if (load_i) begin
               buf_d   = data_i;
               cnt_d   = nbytes_i;
               vld_d   = !tx_busy_i;
               phase_d = ST_TX_REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         phase_q <= ST_IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
      end
   end

   assign tx_vld_o  = vld_q;
   assign tx_data_o = buf_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/sys_cmd_responder.sv
// Command-frame decoder: turns RX byte frames into register-file writes/reads
// and ALU runs, and hands read data / ALU results to the reply sequencer.
module sys_cmd_responder
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int ALU_FUN_WIDTH = 4
) (
   input  logic               clk,
   input  logic               RST,
   sys_cmd_responder_if.master bus
);

   state_t                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic                     wr_en_q, wr_en_d;
   logic                     rd_en_q, rd_en_d;
   logic                     alu_en_q, alu_en_d;
   logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;

   logic                    load;
   logic [1:0]              nbytes;
   logic [2*DATA_WIDTH-1:0] ld_data;
   logic                    tx_done;
   logic                    tx_vld;
   logic [DATA_WIDTH-1:0]   tx_data;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      alu_en_d  = 1'b0;
      alu_fun_d = alu_fun_q;
      load      = 1'b0;
      nbytes    = 2'd0;
      ld_data   = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.RX_D_VLD) begin
               case (bus.RX_P_DATA)
                  CMD_WR:      state_d = ST_WR_ADDR;
                  CMD_RD:      state_d = ST_RD_ADDR;
                  CMD_ALU_OP:  state_d = ST_OP_A;
                  CMD_ALU_NOP: state_d = ST_ALU_FUN;
                  default:     state_d = ST_IDLE;
               endcase
            end
         end
         ST_WR_ADDR: if (bus.RX_D_VLD) begin
            addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = ST_WR_DATA;
         end
         ST_WR_DATA: if (bus.RX_D_VLD) begin
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = ST_IDLE;
         end
         ST_RD_ADDR: if (bus.RX_D_VLD) begin
            addr_d  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: if (bus.RdData_Valid) begin
            load    = 1'b1;
            nbytes  = 2'd1;
            ld_data = {{DATA_WIDTH{1'b0}}, bus.RdData};
            state_d = ST_TX_REQ;
         end
         ST_OP_A: if (bus.RX_D_VLD) begin
            addr_d    = ADDR_WIDTH'(OPA_ADDR);
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = ST_OP_B;
         end
         ST_OP_B: if (bus.RX_D_VLD) begin
            addr_d    = ADDR_WIDTH'(OPB_ADDR);
            wr_data_d = bus.RX_P_DATA;
            wr_en_d   = 1'b1;
            state_d   = ST_ALU_FUN;
         end
         ST_ALU_FUN: if (bus.RX_D_VLD) begin
            alu_fun_d = bus.RX_P_DATA[ALU_FUN_WIDTH-1:0];
            alu_en_d  = 1'b1;
            state_d   = ST_ALU_WAIT;
         end
         ST_ALU_WAIT: if (bus.OUT_Valid) begin
            load    = 1'b1;
            nbytes  = 2'd2;
            ld_data = bus.ALU_OUT;
            state_d = ST_TX_REQ;
         end
         // Reply handshake runs in the sequencer; RX bytes are dropped here.
         ST_TX_REQ, ST_TX_HOLD: if (tx_done) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         alu_en_q  <= 1'b0;
         alu_fun_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         alu_en_q  <= alu_en_d;
         alu_fun_q <= alu_fun_d;
      end
   end

   tx_byte_seq #(.DATA_WIDTH(DATA_WIDTH)) u_tx_seq (
      .clk      (clk),
      .RST      (RST),
      .load_i   (load),
      .nbytes_i (nbytes),
      .data_i   (ld_data),
      .tx_busy_i(bus.TX_busy),
      .tx_vld_o (tx_vld),
      .tx_data_o(tx_data),
      .done_o   (tx_done)
   );

   assign bus.WrEn      = wr_en_q;
   assign bus.RdEn      = rd_en_q;
   assign bus.Address   = addr_q;
   assign bus.WrData    = wr_data_q;
   assign bus.ALU_EN    = alu_en_q;
   assign bus.ALU_FUN   = alu_fun_q;
   assign bus.TX_D_VLD  = tx_vld;
   assign bus.TX_P_DATA = tx_data;

endmodule

// File: tb/tb_sys_cmd_responder.sv
// Scoreboard bench for sys_cmd_responder: stimulus queues expected bus events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_sys_cmd_responder;

   localparam int K_WR  = 0;
   localparam int K_RD  = 1;
   localparam int K_ALU = 2;
   localparam int K_TX  = 3;

   logic clk = 1'b0;
   logic RST = 1'b0;
   always #5 clk = ~clk;

   sys_cmd_responder_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4)) bus ();

   sys_cmd_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALU_FUN_WIDTH(4)) dut (
      .clk(clk),
      .RST(RST),
      .bus(bus)
   );

   typedef struct {
      int kind;
      int a;
      int b;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   logic [7:0]  rd_value  = 8'h00;
   logic [15:0] alu_value = 16'h0000;
   logic        prev_vld  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input int k, input int a, input int b);
      exp_t e;
      e.kind = k; e.a = a; e.b = b;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string name, input int k, input int a, input int b);
      exp_t e;
      if (sb.size() == 0) begin
         total++; bad++;
         $display("FAIL %s: unexpected event a=%0h b=%0h with nothing queued", name, a, b);
      end else begin
         e = sb.pop_front();
         chk({name, "_kind"}, k, e.kind);
         chk({name, "_a"}, a, e.a);
         chk({name, "_b"}, b, e.b);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (RST) begin
         if (bus.WrEn)   pop_chk("wr", K_WR, int'(bus.Address), int'(bus.WrData));
         if (bus.RdEn)   pop_chk("rd", K_RD, int'(bus.Address), 0);
         if (bus.ALU_EN) pop_chk("alu", K_ALU, int'(bus.ALU_FUN), 0);
         if (bus.TX_D_VLD && !bus.TX_busy) pop_chk("tx", K_TX, int'(bus.TX_P_DATA), 0);
         if (prev_vld && !bus.TX_D_VLD) chk("tx_hold_until_busy", int'(bus.TX_busy), 1);
      end
      prev_vld <= bus.TX_D_VLD;
   end

   // Register file: read data returns 2 cycles after RdEn
   always begin
      @(negedge clk);
      if (RST && bus.RdEn) begin
         repeat (2) @(posedge clk);
         #1 bus.RdData = rd_value; bus.RdData_Valid = 1'b1;
         @(posedge clk);
         #1 bus.RdData_Valid = 1'b0;
         chk("rd_reply_latency", int'(bus.TX_D_VLD), 1);
      end
   end

   // ALU: result returns 3 cycles after ALU_EN
   always begin
      @(negedge clk);
      if (RST && bus.ALU_EN) begin
         repeat (3) @(posedge clk);
         #1 bus.ALU_OUT = alu_value; bus.OUT_Valid = 1'b1;
         @(posedge clk);
         #1 bus.OUT_Valid = 1'b0;
         chk("alu_reply_latency", int'(bus.TX_D_VLD), 1);
      end
   end

   // UART transmitter: busy for a few cycles per accepted byte
   always begin
      @(negedge clk);
      if (RST && bus.TX_D_VLD && !bus.TX_busy) begin
         @(posedge clk);
         #1 bus.TX_busy = 1'b1;
         repeat (4) @(posedge clk);
         #1 bus.TX_busy = 1'b0;
      end
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1 bus.RX_P_DATA = b; bus.RX_D_VLD = 1'b1;
      @(posedge clk);
      #1 bus.RX_D_VLD = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         total++; bad++;
         $display("FAIL %s: timeout with %0d events still queued", name, sb.size());
         sb.delete();
      end
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.RX_P_DATA    = '0;
      bus.RX_D_VLD     = 1'b0;
      bus.RdData       = '0;
      bus.RdData_Valid = 1'b0;
      bus.ALU_OUT      = '0;
      bus.OUT_Valid    = 1'b0;
      bus.TX_busy      = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_WrEn",      int'(bus.WrEn), 0);
      chk("rst_RdEn",      int'(bus.RdEn), 0);
      chk("rst_ALU_EN",    int'(bus.ALU_EN), 0);
      chk("rst_TX_D_VLD",  int'(bus.TX_D_VLD), 0);
      chk("rst_Address",   int'(bus.Address), 0);
      chk("rst_WrData",    int'(bus.WrData), 0);
      chk("rst_ALU_FUN",   int'(bus.ALU_FUN), 0);
      chk("rst_TX_P_DATA", int'(bus.TX_P_DATA), 0);
      RST = 1'b1;

      // Register write, no reply
      expect_ev(K_WR, 5, 8'h3C);
      send(8'hAA); send(8'h05); send(8'h3C);
      wait_drain("write");

      // Register read, one reply byte
      rd_value = 8'h3C;
      expect_ev(K_RD, 5, 0);
      expect_ev(K_TX, 8'h3C, 0);
      send(8'hBB); send(8'h05);
      wait_drain("read");

      // ALU with operands: A->reg0, B->reg1, then ALU, reply LSB first
      alu_value = 16'h001E;
      expect_ev(K_WR, 0, 8'h0A);
      expect_ev(K_WR, 1, 8'h03);
      expect_ev(K_ALU, 2, 0);
      expect_ev(K_TX, 8'h1E, 0);
      expect_ev(K_TX, 8'h00, 0);
      send(8'hCC); send(8'h0A); send(8'h03); send(8'h02);
      wait_drain("alu_op");

      // ALU without operands
      alu_value = 16'hABCD;
      expect_ev(K_ALU, 1, 0);
      expect_ev(K_TX, 8'hCD, 0);
      expect_ev(K_TX, 8'hAB, 0);
      send(8'hDD); send(8'h01);
      wait_drain("alu_nop");

      // Unknown opcode, then bytes landing on RdData_Valid and during the reply
      send(8'h55);
      rd_value = 8'h66;
      expect_ev(K_RD, 3, 0);
      expect_ev(K_TX, 8'h66, 0);
      send(8'hBB); send(8'h03);
      @(posedge clk);
      send(8'hAA); send(8'h09); send(8'h7F);
      wait_drain("drops_read");
      expect_ev(K_WR, 2, 8'h7F);
      send(8'hAA); send(8'h02); send(8'h7F);
      wait_drain("after_drops");

      // Reset between the two ALU reply bytes
      alu_value = 16'h1234;
      expect_ev(K_ALU, 4, 0);
      expect_ev(K_TX, 8'h34, 0);
      send(8'hDD); send(8'h04);
      begin
         int n = 0;
         while (!(bus.TX_busy && !bus.TX_D_VLD && sb.size() == 0) && n < 300) begin
            @(negedge clk);
            n++;
         end
         chk("reach_tx_hold", int'(n < 300), 1);
      end
      #2 RST = 1'b0;
      #1;
      chk("midrst_TX_P_DATA", int'(bus.TX_P_DATA), 0);
      chk("midrst_ALU_FUN",   int'(bus.ALU_FUN), 0);
      chk("midrst_TX_D_VLD",  int'(bus.TX_D_VLD), 0);
      chk("midrst_Address",   int'(bus.Address), 0);
      repeat (2) @(negedge clk);
      RST = 1'b1;
      repeat (30) @(negedge clk);
      chk("queue_empty_end", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
